// File: rtl/rr_req_arbiter_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
// The master side drives req; the slave (the arbiter) returns the registered grant.
interface rr_req_arbiter_if #(
  parameter int N = 8
);
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic         busy;
  logic         dbg_state;

  modport master (output req, input gnt, input gnt_valid, input busy, input dbg_state);
  modport slave  (input req, output gnt, output gnt_valid, output busy, output dbg_state);
endinterface

// File: rtl/rr_req_arbiter.sv
// Registered round-robin arbiter feeding a one-hot encoder: gnt is one-hot or zero,
// gnt_valid is its enable, and an owner is preempted after MAX_HOLD cycles of contention.
module rr_req_arbiter #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic           clk,
  input  logic           rst,
  rr_req_arbiter_if.slave bus
);
  // Handshake: req bits are level requests sampled every rising edge; a requester
  // owns the bus while its gnt bit is high and releases it by dropping its req bit.
  localparam int             IW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [7:0]     MAX_H    = 8'(MAX_HOLD);
  localparam logic [IW-1:0]  LAST_RST = IW'(N - 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t        state, state_n;
  logic [N-1:0]  gnt_q, gnt_n;
  logic          gnt_valid_q, busy_q;
  logic [7:0]    hold_cnt, hold_n;
  logic [IW-1:0] last_idx, last_n;
  logic [N-1:0]  owner_oh, others;

  // First set bit of r scanning upward from (from+1) with wrap-around.
  function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] r, input logic [IW-1:0] from);
    logic [IW-1:0] pick;
    logic [IW-1:0] idx;
    logic          found;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(from) + k) % N);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [IW-1:0] i);
    logic [N-1:0] oh;
    oh    = '0;
    oh[i] = 1'b1;
    return oh;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      hold_cnt    <= 8'd0;
      last_idx    <= LAST_RST;
    end else begin
      state       <= state_n;
      gnt_q       <= gnt_n;
      gnt_valid_q <= |gnt_n;
      busy_q      <= (state_n == GRANT);
      hold_cnt    <= hold_n;
      last_idx    <= last_n;
    end
  end

  // While in GRANT the owner is always last_idx, since every new grant records it.
  always_comb begin
    state_n  = state;
    gnt_n    = gnt_q;
    hold_n   = hold_cnt;
    last_n   = last_idx;
    owner_oh = onehot(last_idx);
    others   = bus.req & ~owner_oh;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          last_n  = rr_pick(bus.req, last_idx);
          gnt_n   = onehot(last_n);
          hold_n  = 8'd1;
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (((bus.req & owner_oh) != '0) && ((others == '0) || (hold_cnt < MAX_H))) begin
          if (hold_cnt < MAX_H) hold_n = hold_cnt + 8'd1;
        end else if (others != '0) begin
          last_n = rr_pick(others, last_idx);
          gnt_n  = onehot(last_n);
          hold_n = 8'd1;
        end else begin
          gnt_n   = '0;
          hold_n  = 8'd0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.gnt       = gnt_q;
    bus.gnt_valid = gnt_valid_q;
    bus.busy      = busy_q;
    bus.dbg_state = state;
  end
endmodule

// File: tb/tb_rr_req_arbiter.sv
// Self-checking bench for rr_req_arbiter: directed vector table, a preemption
// rotation sequence, and randomized traffic against a behavioural model.
module tb_rr_req_arbiter;
  localparam int N        = 8;
  localparam int MAX_HOLD = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_req_arbiter_if #(.N(N)) bus();

  rr_req_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
  } vec_t;

  vec_t vecs[$];
  logic [N-1:0] exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: owner index (-1 when idle), consecutive hold count, last owner.
  int m_owner = -1;
  int m_hold  = 0;
  int m_last  = N - 1;

  function automatic int pick_from(input logic [N-1:0] r, input int from);
    for (int k = 1; k <= N; k++) begin
      if (r[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  task automatic model_step(input logic r, input logic [N-1:0] q);
    logic [N-1:0] others;
    if (r) begin
      m_owner = -1; m_hold = 0; m_last = N - 1;
    end else if (m_owner < 0) begin
      if (q != 0) begin
        m_owner = pick_from(q, m_last); m_hold = 1; m_last = m_owner;
      end
    end else begin
      others = q;
      others[m_owner] = 1'b0;
      if (q[m_owner] && (others == 0 || m_hold < MAX_HOLD)) begin
        m_hold = (m_hold + 1 > MAX_HOLD) ? MAX_HOLD : m_hold + 1;
      end else if (others != 0) begin
        m_owner = pick_from(others, m_owner); m_hold = 1; m_last = m_owner;
      end else begin
        m_owner = -1; m_hold = 0;
      end
    end
  endtask

  function automatic logic [N-1:0] model_gnt();
    logic [N-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Drive one cycle, advance the model at the edge, then compare #1 after it.
  task automatic apply(input logic r, input logic [N-1:0] q);
    logic [N-1:0] e;
    rst     = r;
    bus.req = q;
    @(posedge clk);
    model_step(r, q);
    exp_q.push_back(model_gnt());
    #1;
    e = exp_q.pop_front();
    check("gnt", 32'(bus.gnt), 32'(e));
    check("gnt_valid", 32'(bus.gnt_valid), 32'(|e));
    check("busy", 32'(bus.busy), 32'(m_owner >= 0));
    check("dbg_state", 32'(bus.dbg_state), 32'(m_owner >= 0));
    check("onehot", 32'($countones(bus.gnt) <= 1), 32'd1);
  endtask

  initial begin
    int hold_left;
    logic [N-1:0] rq;
    logic [N-1:0] e;
    rst     = 1'b1;
    bus.req = '0;

    // reset with all requests, then release
    vecs.push_back('{1'b1, 8'hFF, 8'h00});
    vecs.push_back('{1'b1, 8'hFF, 8'h00});
    vecs.push_back('{1'b0, 8'hFF, 8'h01});
    vecs.push_back('{1'b0, 8'h00, 8'h00});
    // lone requester holds past MAX_HOLD
    for (int i = 0; i < 10; i++) vecs.push_back('{1'b0, 8'h10, 8'h10});
    vecs.push_back('{1'b0, 8'h00, 8'h00});
    // owner 2 handoff to 7 with no gap, then last_idx=7 favours bit 0
    vecs.push_back('{1'b1, 8'h00, 8'h00});
    vecs.push_back('{1'b0, 8'h84, 8'h04});
    vecs.push_back('{1'b0, 8'h80, 8'h80});
    vecs.push_back('{1'b0, 8'h00, 8'h00});
    vecs.push_back('{1'b0, 8'h05, 8'h01});
    vecs.push_back('{1'b0, 8'h00, 8'h00});
    // grant 5, release, search restarts at 6 and wraps to 0
    vecs.push_back('{1'b0, 8'h20, 8'h20});
    vecs.push_back('{1'b0, 8'h00, 8'h00});
    vecs.push_back('{1'b0, 8'h21, 8'h01});
    vecs.push_back('{1'b0, 8'h00, 8'h00});
    // reset during an active grant restarts priority at bit 0
    vecs.push_back('{1'b0, 8'h08, 8'h08});
    vecs.push_back('{1'b1, 8'h08, 8'h00});
    vecs.push_back('{1'b0, 8'h09, 8'h01});
    vecs.push_back('{1'b0, 8'h00, 8'h00});

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].req);
      check($sformatf("vec%0d", i), 32'(bus.gnt), 32'(vecs[i].gnt));
    end

    // all requesting: each owner holds exactly MAX_HOLD cycles, rotating upward
    apply(1'b1, 8'h00);
    for (int c = 0; c < MAX_HOLD * N + MAX_HOLD; c++) begin
      apply(1'b0, 8'hFF);
      e = '0;
      e[(c / MAX_HOLD) % N] = 1'b1;
      check("rotate", 32'(bus.gnt), 32'(e));
      check("rotate_valid", 32'(bus.gnt_valid), 32'd1);
    end
    apply(1'b0, 8'h00);

    // randomized traffic held for a few cycles at a time
    hold_left = 0;
    rq = '0;
    for (int c = 0; c < 2000; c++) begin
      if (hold_left == 0) begin
        case ($urandom_range(0, 3))
          0:       rq = '0;
          1:       rq = N'(1 << $urandom_range(0, N - 1));
          default: rq = N'($urandom);
        endcase
        hold_left = $urandom_range(1, 8);
      end
      hold_left--;
      apply($urandom_range(0, 99) == 0, rq);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/rr_req_arbiter.md
Name: rr_req_arbiter

Overview:
- Registered 8-input round-robin arbiter that sits directly upstream of the 8-to-3 one-hot encoder.
- Collects up to N simultaneous request lines and issues exactly one one-hot grant, or none.
- gnt drives the encoder's one-hot input; gnt_valid drives its enable.
- Guarantees the encoder only ever sees legal one-hot codes or all-zero with enable low.

Parameters:
N, 8, number of request lines (gnt width); the encoder pairing requires 8.
MAX_HOLD, 4, maximum consecutive cycles one owner keeps the grant while other requesters wait; legal range 1..255.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
req  input  N  request lines, level-sensitive, bit i = requester i
gnt  output  N  registered grant, one-hot or all-zero
gnt_valid  output  1  registered; equals OR of gnt
busy  output  1  registered; high while any grant is held

Behaviour:
- Single clock domain; reset is synchronous and active-high. The clock port is clk and the reset port is rst.
- Reset values:
  - gnt=0, gnt_valid=0, busy=0.
  - State=IDLE, hold_cnt=0.
  - last_idx=N-1, so requester 0 has highest priority after reset.
- Reset asserted mid-grant clears everything at that edge; gnt is 0 the cycle after.
- States: IDLE, GRANT.
- Priority search: start at (last_idx+1) mod N, scan upward with wrap-around, and pick the first set bit. A new owner's index is written to last_idx.
- IDLE:
  - If req != 0 at an edge: gnt = one-hot(winner) after that edge, hold_cnt=1, go to GRANT.
  - Latency from req to gnt is 1 cycle.
- GRANT (owner index o):
  - req[o]=1, and either no other req bit set or hold_cnt<MAX_HOLD: keep gnt. hold_cnt increments, saturating at MAX_HOLD.
  - req[o]=1, another bit set, and hold_cnt==MAX_HOLD: preempt. Grant the next requester searched from o+1 at this edge, hold_cnt=1.
  - req[o]=0 and other bits set: direct handoff at this edge to the next requester searched from o+1, hold_cnt=1. There is no idle gap.
  - req[o]=0 and no bits set: gnt=0, hold_cnt=0, go to IDLE. last_idx is retained.
- A lone requester holds indefinitely. hold_cnt stays at MAX_HOLD and no preemption occurs.
- A requester whose bit drops and rises again waits its round-robin turn; it gets no re-grant priority.
- Invariants on every cycle:
  - popcount(gnt) ≤ 1.
  - gnt_valid == |gnt and busy == (state==GRANT).
  - gnt is never asserted to a bit whose req was low at the granting edge.
- All outputs come from flops; there is no combinational path from req to gnt.
- hold_cnt width is 8 bits.
- Starvation bound: a continuously asserted request is granted within (N-1)*MAX_HOLD+1 cycles of the edge at which it is first sampled.

Test Plan:
1. rst=1 for 2 cycles with req=8'hFF → gnt=0, gnt_valid=0 throughout. Release rst with req=8'hFF → gnt=8'h01 one cycle later.
2. req=8'b0001_0000 held for 10 cycles → gnt=8'b0001_0000 from cycle 1 to cycle 10, with no preemption. Drop req → gnt=0 and busy=0 the next cycle.
3. req=8'hFF held, MAX_HOLD=4 → gnt=01 for 4 cycles, then 02, 04, …, 80, then back to 01. Each grant lasts exactly 4 cycles and gnt_valid stays continuously high.
4. Owner 2 granted with req=8'b1000_0100; drop bit 2 → gnt=8'h80 on the next cycle with no zero gap. last_idx=7, so a subsequent req=8'h05 grants 01 before 04.
5. Rotation fairness: grant 5, release it, then assert req=8'b0010_0001 → gnt=8'h01, since the search starts at index 6 and wraps.
6. Assert rst during an active grant (gnt=8'h08) → gnt=0 after that edge. After release, priority restarts at bit 0, so req=8'h09 → gnt=8'h01.
